// File: rtl/mul_arb_sched.sv
// Two-requester round-robin front end for one shared, LATENCY-deep 5x14 multiplier.
// Optional saturating per-requester grant counters are built when MUL_ARB_STATS_EN is defined.
module mul_arb_sched #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [4:0]        req_a0,
  input  logic [4:0]        req_a1,
  input  logic [13:0]       req_b0,
  input  logic [13:0]       req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [18:0]       rsp_p,
  output logic              mul_ce,
  output logic [4:0]        mul_a,
  output logic [13:0]       mul_b,
  input  logic [18:0]       mul_p
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_grant0,
  output logic [CNT_W-1:0]  cnt_grant1
`endif
);

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0] tag_pipe_q, tag_pipe_d;
  logic               ptr_q, ptr_d;
  logic               out_vld, out_tag, stall, grant, win;

  assign out_vld = vld_pipe_q[LATENCY-1];
  assign out_tag = tag_pipe_q[LATENCY-1];
  // A bubble at the output never stalls; only an unconsumed valid result does.
  assign stall   = out_vld & ~rsp_ready[out_tag];
  assign mul_ce  = ~stall;

  assign win       = (&req_valid) ? ptr_q : req_valid[1];
  // rst_n gates the grant so ready/operands are quiet during an asynchronous reset.
  assign grant     = rst_n & (|req_valid) & ~stall;
  assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign mul_a     = grant ? (win ? req_a1 : req_a0) : 5'd0;
  assign mul_b     = grant ? (win ? req_b1 : req_b0) : 14'd0;

  assign rsp_valid = out_vld ? (out_tag ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_p     = mul_p;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    tag_pipe_d = tag_pipe_q;
    ptr_d      = ptr_q;
    if (mul_ce) begin
      vld_pipe_d[0] = grant;
      tag_pipe_d[0] = grant & win;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        tag_pipe_d[i] = tag_pipe_q[i-1];
      end
      if (grant) ptr_d = ~win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      ptr_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef MUL_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req_ready[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
      if (req_ready[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt_grant0 = cnt0_q;
  assign cnt_grant1 = cnt1_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mul_arb_sched.sv
// Randomized scoreboard bench for mul_arb_sched with a behavioural multiplier model.
module tb_mul_arb_sched;
  localparam int LAT = 3;
`ifdef MUL_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
  logic [4:0]  req_a0 = '0, req_a1 = '0, mul_a;
  logic [13:0] req_b0 = '0, req_b1 = '0, mul_b;
  logic [18:0] rsp_p, mul_p;
  logic        mul_ce;
`ifdef MUL_ARB_STATS_EN
  logic [CW-1:0] cnt_grant0, cnt_grant1;
`endif

  mul_arb_sched #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
`ifdef MUL_ARB_STATS_EN
    , .cnt_grant0(cnt_grant0), .cnt_grant1(cnt_grant1)
`endif
  );

  always #5 clk = ~clk;

  // Shared DSP multiplier: LAT ce-qualified register stages.
  logic [18:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mul_a * mul_b;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p = mpipe[LAT-1];

  typedef struct { int tag; int p; int issue; int st; } exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_fail = 0;
  int   ptr = 0, cyc = 0, stalls = 0, w = 0, ea = 0, eb = 0;
  int   cnt_m[2] = '{0, 0};
  bit   seen = 0, exp_stall = 0;
  logic [1:0] er;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  // Monitor / scoreboard: everything is settled at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mul_ce", mul_ce, 1);
      chk("rst_mul_ab", {mul_a, mul_b}, 0);
      q.delete();
      ptr = 0; seen = 0; cnt_m = '{0, 0};
    end else begin
`ifdef MUL_ARB_STATS_EN
      chk("cnt_grant0", cnt_grant0, sat(cnt_m[0]));
      chk("cnt_grant1", cnt_grant1, sat(cnt_m[1]));
`endif
      exp_stall = (rsp_valid[0] && !rsp_ready[0]) || (rsp_valid[1] && !rsp_ready[1]);
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          chk("rsp_valid", rsp_valid, q[0].tag ? 2 : 1);
          chk("rsp_p", rsp_p, q[0].p);
          if (!seen) chk("rsp_latency", cyc - q[0].issue, LAT + stalls - q[0].st);
          seen = 1;
          if (!exp_stall) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      chk("mul_ce", mul_ce, !exp_stall);
      er = 2'b00;
      if (!exp_stall && req_valid != 2'b00) begin
        w  = (req_valid == 2'b11) ? ptr : (req_valid[1] ? 1 : 0);
        er = w ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, er);
      if (er != 2'b00) begin
        ea = w ? req_a1 : req_a0;
        eb = w ? req_b1 : req_b0;
        chk("mul_ab", {mul_a, mul_b}, (ea << 14) | eb);
        q.push_back('{w, ea * eb, cyc, stalls});
        ptr = 1 - w;
        cnt_m[w]++;
      end else if (req_valid == 2'b00) begin
        chk("mul_ab_idle", {mul_a, mul_b}, 0);
      end
      if (exp_stall) stalls++;
    end
  end

  task automatic tick(input logic [1:0] rv, input logic [1:0] rr);
    @(posedge clk); #1;
    req_valid = rv; rsp_ready = rr;
    req_a0 = 5'($urandom); req_a1 = 5'($urandom);
    req_b0 = 14'($urandom); req_b1 = 14'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // First request right after reset release: max operands from requester 0.
    rst_n = 1'b1; req_valid = 2'b01; req_a0 = 5'd31; req_b0 = 14'd16383; rsp_ready = 2'b11;
    @(posedge clk); #1; req_valid = 2'b00;
    repeat (5) tick(2'b00, 2'b11);
    // Continuous contention, then contention against a blocked requester 1.
    repeat (6) tick(2'b11, 2'b11);
    repeat (5) tick(2'b00, 2'b11);
    repeat (6) tick(2'b11, 2'b01);
    repeat (3) tick(2'b00, 2'b01);
    repeat (6) tick(2'b00, 2'b11);
    // Reset with results in flight, then contention must favour requester 0.
    repeat (3) tick(2'b11, 2'b11);
    @(posedge clk); #1; rst_n = 1'b0; req_valid = 2'b00;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) tick(2'b11, 2'b11);
    repeat (5) tick(2'b00, 2'b11);
    // Long run of requester-0 grants (saturates small counters).
    repeat (20) tick(2'b01, 2'b11);
    repeat (5) tick(2'b00, 2'b11);
    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      tick(2'($urandom), {($urandom_range(3) != 0), ($urandom_range(3) != 0)});
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
      end
    end
    tick(2'b00, 2'b11);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk); #1;
    chk("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arb_sched.md
MUL_ARB_SCHED -- requirements
Module: mul_arb_sched

Interface
REQ-001 Parameter LATENCY, default 3: ce-qualified clock edges from mul_a/mul_b to mul_p, matching the 5x14 unsigned DSP multiplier register depth.
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  2  per-requester operand valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester operand accepted this cycle.
REQ-007 req_a0, req_a1  input  5 each  unsigned multiplicand of requester 0 and 1.
REQ-008 req_b0, req_b1  input  14 each  unsigned multiplier of requester 0 and 1.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result consumed.
REQ-011 rsp_p  output  19  unsigned product, shared by both requesters and qualified by rsp_valid.
REQ-012 mul_ce  output  1  clock enable to the shared multiplier.
REQ-013 mul_a  output  5  operand to the shared multiplier.
REQ-014 mul_b  output  14  operand to the shared multiplier.
REQ-015 mul_p  input  19  product from the shared multiplier.
REQ-016 cnt_grant0, cnt_grant1  output  CNT_W each  grant counters; present only with MUL_ARB_STATS_EN.

Function
REQ-017 The block shall time-share one multiplier between two requesters, issuing at most one operand pair per cycle.
REQ-018 Arbitration shall be round-robin: when both requesters are valid, the requester not granted most recently wins; a single valid requester wins immediately.
REQ-019 After reset the round-robin pointer shall favour requester 0.
REQ-020 req_ready[i] shall be high only when requester i wins arbitration and stall is low; at most one bit is set, and req_ready is never high for a requester whose req_valid is low.
REQ-021 mul_a/mul_b shall combinationally carry the winner's operands; with no winner they shall be 0.
REQ-022 A LATENCY-deep valid/tag shift register shall advance only when mul_ce is high; its entry stage loads {accepted, winner index}, and a bubble is loaded when nothing is accepted.
REQ-023 With stall low, a result for an operand pair accepted at edge T shall appear on rsp_p/rsp_valid at edge T+LATENCY.
REQ-024 The output stage shall drive rsp_valid[tag] = out_valid and rsp_p = mul_p; the other rsp_valid bit shall be 0.
REQ-025 stall = out_valid AND NOT rsp_ready[out_tag]; mul_ce = NOT stall.
REQ-026 While stall is high, the shift register, multiplier and pointer shall hold, rsp_p and rsp_valid shall remain stable, and no request shall be accepted.
REQ-027 A bubble at the output stage shall never stall the pipeline.
REQ-028 Sustained throughput shall be one product per cycle, with no lost or duplicated results, and results returned in issue order.
REQ-029 Products shall be full-width, 5b x 14b -> 19b unsigned, with no truncation.

Reset
REQ-030 While rst_n is low: the valid pipe clears, the pointer is set to requester 0, and counters are set to 0.
REQ-031 While rst_n is low: rsp_valid=0, req_ready=0, mul_ce=1, mul_a=0, mul_b=0.
REQ-032 Reset asserted mid-operation shall discard all in-flight results; no rsp_valid is raised for them after release.
REQ-033 The first request may be accepted in the first cycle after rst_n deasserts.

Configuration
REQ-034 With macro MUL_ARB_STATS_EN defined, cnt_grant0/cnt_grant1 shall count accepted requests per requester and saturate at all-ones.
REQ-035 Without MUL_ARB_STATS_EN, the counters and their ports shall be absent, and all other behaviour shall be identical.

Verification
REQ-036 Req0 only, a=31, b=16383 at edge 10 -> rsp_valid=01 and rsp_p=507873 at edge 13; req_ready=01 at edge 10 only.
REQ-037 Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; results return in that order, one per cycle.
REQ-038 Pipe full, rsp_ready[1]=0 for 3 cycles while the output tag is 1 -> mul_ce=0, rsp_p held, req_ready=00; after release the next result follows on the next edge with none lost.
REQ-039 rst_n pulsed low with 3 results in flight -> no rsp_valid afterwards; the pointer favours requester 0 on the first contention.
REQ-040 MUL_ARB_STATS_EN defined, CNT_W=4, 20 req0 grants -> cnt_grant0=15 (saturated), cnt_grant1=0.
